// File: rtl/alu_issue_pkg.sv
// Shared ALU opcode encoding, RV32I major opcodes and the issue-entry record
// used by both the decoder and the skid buffer.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } issue_entry_t;

  // funct3 -> ALU op; alt selects SUB/SRA in the two slots that have variants.
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decoded ALU operation bundle: opcode, operands, destination and illegal flag.
interface alu_issue_if;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        illegal;

  modport master (output op, a, b, rd, illegal);
  modport slave  (input  op, a, b, rd, illegal);
endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I integer-ALU decoder; illegal words collapse to a zeroed ADD.
module alu_decode
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  alu_issue_if.master     dec_if
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            legal;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    legal = 1'b0;
    op    = ALU_ADD;
    a     = '0;
    b     = '0;
    case (opcode)
      OPC_OP: begin
        a = rs1_i;
        b = rs2_i;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          op    = f3_to_op(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal = 1'b1;
          op    = f3_to_op(funct3, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        a = rs1_i;
        b = {{20{instr_i[31]}}, instr_i[31:20]};
        if (funct3 == 3'b001) begin
          b     = {27'b0, instr_i[24:20]};
          legal = (funct7 == F7_BASE);
          op    = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          b     = {27'b0, instr_i[24:20]};
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          op    = instr_i[30] ? ALU_SRA : ALU_SRL;
        end else begin
          // ADDI never becomes SUB: the immediate form has no funct7.
          legal = 1'b1;
          op    = f3_to_op(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        b     = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a     = pc_i;
        b     = {instr_i[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  assign dec_if.op      = legal ? op : ALU_ADD;
  assign dec_if.a       = legal ? a : '0;
  assign dec_if.b       = legal ? b : '0;
  assign dec_if.rd      = legal ? instr_i[11:7] : 5'd0;
  assign dec_if.illegal = ~legal;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decoder feeding a 2-entry skid buffer (output + skid register)
// with fully registered ready toward upstream.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            iClk,
  input  logic            nRst,
  input  logic            iFlush,
  input  logic            iValid,
  output logic            oReady,
  input  logic [31:0]     iInstr,
  input  logic [XLEN-1:0] iPC,
  input  logic [XLEN-1:0] iRs1,
  input  logic [XLEN-1:0] iRs2,
  output logic            oValid,
  input  logic            iReady,
  output logic [3:0]      oOP,
  output logic [XLEN-1:0] oA,
  output logic [XLEN-1:0] oB,
  output logic [4:0]      oRd,
  output logic            oIllegal
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  alu_issue_if dec_if ();

  alu_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (iInstr),
    .pc_i    (iPC),
    .rs1_i   (iRs1),
    .rs2_i   (iRs2),
    .dec_if  (dec_if.master)
  );

  state_e       state_q, state_d;
  issue_entry_t out_q, out_d;
  issue_entry_t skid_q, skid_d;
  issue_entry_t dec_entry;
  logic         ready_q;
  logic         accept;

  assign dec_entry = '{op: dec_if.op, a: dec_if.a, b: dec_if.b,
                       rd: dec_if.rd, illegal: dec_if.illegal};

  // ready_q is low in TWO, so accept can never fire there.
  assign accept = iValid && ready_q && !iFlush;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (iFlush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_d   = dec_entry;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && iReady) begin
            out_d = dec_entry;
          end else if (accept) begin
            skid_d  = dec_entry;
            state_d = S_TWO;
          end else if (iReady) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (iReady) begin
            out_d   = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != S_TWO);
    end
  end

  assign oReady   = ready_q;
  assign oValid   = (state_q != S_EMPTY);
  assign oOP      = out_q.op;
  assign oA       = out_q.a;
  assign oB       = out_q.b;
  assign oRd      = out_q.rd;
  assign oIllegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode results, skid ordering, flush and reset.
module tb_alu_issue;

  logic        iClk;
  logic        nRst;
  logic        iFlush;
  logic        iValid;
  logic        oReady;
  logic [31:0] iInstr;
  logic [31:0] iPC;
  logic [31:0] iRs1;
  logic [31:0] iRs2;
  logic        oValid;
  logic        iReady;

  int checks   = 0;
  int failures = 0;

  alu_issue_if mon_if ();

  alu_issue #(.XLEN(32)) dut (
    .iClk     (iClk),
    .nRst     (nRst),
    .iFlush   (iFlush),
    .iValid   (iValid),
    .oReady   (oReady),
    .iInstr   (iInstr),
    .iPC      (iPC),
    .iRs1     (iRs1),
    .iRs2     (iRs2),
    .oValid   (oValid),
    .iReady   (iReady),
    .oOP      (mon_if.op),
    .oA       (mon_if.a),
    .oB       (mon_if.b),
    .oRd      (mon_if.rd),
    .oIllegal (mon_if.illegal)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SRAI  = 32'h4030D213; // srai x4,x1,3
  localparam logic [31:0] I_SUB   = 32'h402082B3; // sub  x5,x1,x2
  localparam logic [31:0] I_SLTI  = 32'hFFF0A313; // slti x6,x1,-1
  localparam logic [31:0] I_AUIPC = 32'h12345097; // auipc x1,0x12345
  localparam logic [31:0] I_LUI   = 32'hABCDE3B7; // lui  x7,0xABCDE
  localparam logic [31:0] I_LW    = 32'h00012083; // lw   x1,0(x2)
  localparam logic [31:0] I_BADF7 = 32'h202081B3; // OP with funct7=0010000

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    iValid = 1'b1;
    iInstr = instr;
    iPC    = pc;
    iRs1   = rs1;
    iRs2   = rs2;
    $display("drive instr=0x%08h pc=0x%08h rs1=0x%08h rs2=0x%08h", instr, pc, rs1, rs2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRst = 1'b0; iFlush = 1'b0; iValid = 1'b0; iReady = 1'b1;
    iInstr = '0; iPC = '0; iRs1 = '0; iRs2 = '0;
    step(); step();
    chk("rst_valid",   {31'b0, oValid}, 32'd0);
    chk("rst_ready",   {31'b0, oReady}, 32'd0);
    chk("rst_op",      {28'b0, mon_if.op}, 32'd0);
    chk("rst_a",       mon_if.a, 32'd0);
    chk("rst_b",       mon_if.b, 32'd0);
    chk("rst_rd",      {27'b0, mon_if.rd}, 32'd0);
    chk("rst_illegal", {31'b0, mon_if.illegal}, 32'd0);

    nRst = 1'b1;
    step();
    chk("post_rst_ready", {31'b0, oReady}, 32'd1);
    chk("post_rst_valid", {31'b0, oValid}, 32'd0);

    // Streaming decode at one op per cycle
    drive(I_ADD, 32'h0, 32'd5, 32'd7);
    step();
    chk("add_valid", {31'b0, oValid}, 32'd1);
    chk("add_op", {28'b0, mon_if.op}, 32'd0);
    chk("add_a", mon_if.a, 32'd5);
    chk("add_b", mon_if.b, 32'd7);
    chk("add_rd", {27'b0, mon_if.rd}, 32'd3);
    chk("add_illegal", {31'b0, mon_if.illegal}, 32'd0);

    drive(I_SRAI, 32'h0, 32'h8000_0000, 32'd99);
    step();
    chk("srai_op", {28'b0, mon_if.op}, 32'd7);
    chk("srai_a", mon_if.a, 32'h8000_0000);
    chk("srai_b", mon_if.b, 32'd3);
    chk("srai_rd", {27'b0, mon_if.rd}, 32'd4);

    drive(I_SUB, 32'h0, 32'd10, 32'd4);
    step();
    chk("sub_op", {28'b0, mon_if.op}, 32'd1);
    chk("sub_b", mon_if.b, 32'd4);
    chk("sub_rd", {27'b0, mon_if.rd}, 32'd5);

    drive(I_SLTI, 32'h0, 32'd1, 32'd0);
    step();
    chk("slti_op", {28'b0, mon_if.op}, 32'd8);
    chk("slti_b", mon_if.b, 32'hFFFF_FFFF);

    drive(I_AUIPC, 32'h100, 32'd77, 32'd88);
    step();
    chk("auipc_op", {28'b0, mon_if.op}, 32'd0);
    chk("auipc_a", mon_if.a, 32'h100);
    chk("auipc_b", mon_if.b, 32'h1234_5000);
    chk("auipc_rd", {27'b0, mon_if.rd}, 32'd1);

    drive(I_LUI, 32'h200, 32'd77, 32'd88);
    step();
    chk("lui_a", mon_if.a, 32'd0);
    chk("lui_b", mon_if.b, 32'hABCD_E000);
    chk("lui_rd", {27'b0, mon_if.rd}, 32'd7);

    drive(I_LW, 32'h300, 32'd55, 32'd66);
    step();
    chk("load_illegal", {31'b0, mon_if.illegal}, 32'd1);
    chk("load_op", {28'b0, mon_if.op}, 32'd0);
    chk("load_a", mon_if.a, 32'd0);
    chk("load_b", mon_if.b, 32'd0);
    chk("load_rd", {27'b0, mon_if.rd}, 32'd0);

    drive(I_BADF7, 32'h0, 32'd1, 32'd2);
    step();
    chk("badf7_illegal", {31'b0, mon_if.illegal}, 32'd1);

    iValid = 1'b0;
    step();
    chk("drain_valid", {31'b0, oValid}, 32'd0);

    // Back-pressure: X then Y must both come out in order
    iReady = 1'b0;
    drive(I_ADD, 32'h0, 32'd11, 32'd22);
    step();
    chk("skid_x_valid", {31'b0, oValid}, 32'd1);
    chk("skid_x_ready", {31'b0, oReady}, 32'd1);
    drive(I_SUB, 32'h0, 32'd33, 32'd44);
    step();
    chk("skid_two_ready", {31'b0, oReady}, 32'd0);
    chk("skid_x_held_a", mon_if.a, 32'd11);
    chk("skid_x_held_op", {28'b0, mon_if.op}, 32'd0);
    drive(I_LUI, 32'h0, 32'd0, 32'd0);
    step();
    chk("skid_x_stable_a", mon_if.a, 32'd11);
    chk("skid_x_stable_b", mon_if.b, 32'd22);
    chk("skid_x_stable_rd", {27'b0, mon_if.rd}, 32'd3);
    iValid = 1'b0;
    iReady = 1'b1;
    step();
    chk("skid_y_valid", {31'b0, oValid}, 32'd1);
    chk("skid_y_op", {28'b0, mon_if.op}, 32'd1);
    chk("skid_y_a", mon_if.a, 32'd33);
    chk("skid_y_b", mon_if.b, 32'd44);
    chk("skid_y_rd", {27'b0, mon_if.rd}, 32'd5);
    chk("skid_y_ready", {31'b0, oReady}, 32'd1);
    step();
    chk("skid_empty_valid", {31'b0, oValid}, 32'd0);

    // Flush while full, with a competing input
    iReady = 1'b0;
    drive(I_ADD, 32'h0, 32'd1, 32'd2);
    step();
    drive(I_SUB, 32'h0, 32'd3, 32'd4);
    step();
    chk("flush_pre_ready", {31'b0, oReady}, 32'd0);
    iFlush = 1'b1;
    drive(I_LUI, 32'h0, 32'd0, 32'd0);
    step();
    chk("flush_valid", {31'b0, oValid}, 32'd0);
    chk("flush_ready", {31'b0, oReady}, 32'd1);
    iFlush = 1'b0;
    iValid = 1'b0;
    iReady = 1'b1;
    step();
    chk("flush_no_issue", {31'b0, oValid}, 32'd0);

    // Reset in the middle of a stall
    iReady = 1'b0;
    drive(I_AUIPC, 32'h400, 32'd0, 32'd0);
    step();
    drive(I_SUB, 32'h0, 32'd9, 32'd8);
    step();
    nRst = 1'b0;
    iValid = 1'b0;
    step();
    chk("mid_rst_valid", {31'b0, oValid}, 32'd0);
    chk("mid_rst_ready", {31'b0, oReady}, 32'd0);
    chk("mid_rst_op", {28'b0, mon_if.op}, 32'd0);
    chk("mid_rst_a", mon_if.a, 32'd0);
    chk("mid_rst_b", mon_if.b, 32'd0);
    chk("mid_rst_rd", {27'b0, mon_if.rd}, 32'd0);
    chk("mid_rst_illegal", {31'b0, mon_if.illegal}, 32'd0);
    nRst = 1'b1;
    iReady = 1'b1;
    step();
    chk("mid_rst_rel_ready", {31'b0, oReady}, 32'd1);
    chk("mid_rst_rel_valid", {31'b0, oValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port iClk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRst  in  1  synchronous active-low reset.
REQ-004 SHALL have port iFlush  in  1  discard all held entries.
REQ-005 SHALL have port iValid  in  1  upstream instruction valid.
REQ-006 SHALL have port oReady  out  1  block accepts an input this cycle.
REQ-007 SHALL have port iInstr  in  32  RV32I instruction word.
REQ-008 SHALL have port iPC  in  32  instruction address.
REQ-009 SHALL have port iRs1, iRs2  in  32 each  register-file read values.
REQ-010 SHALL have port oValid  out  1  issued op valid toward the ALU.
REQ-011 SHALL have port iReady  in  1  ALU consumer accepts the op.
REQ-012 SHALL have port oOP  out  4  ALU opcode; oA, oB  out  32 each  ALU operands.
REQ-013 SHALL have port oRd  out  5  destination register; oIllegal  out  1  unsupported instruction flag.

Function
REQ-014 SHALL encode oOP as ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
REQ-015 SHALL accept an input when iValid && oReady && !iFlush.
REQ-016 SHALL decode OP (0110011): funct3 000 -> ADD, or SUB if funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7=0100000; 110 OR; 111 AND; A=iRs1, B=iRs2.
REQ-017 SHALL decode OP-IMM (0010011) with the OP mapping, never SUB; A=iRs1, B=sign-extended I-imm; for shifts, B=zero-extended shamt (instr[24:20]) and SRAI is selected by instr[30].
REQ-018 SHALL decode LUI (0110111) as ADD, A=0, B={instr[31:12],12'b0}.
REQ-019 SHALL decode AUIPC (0010111) as ADD, A=iPC, B=U-imm.
REQ-020 SHALL mark as illegal: any other opcode; OP funct7 outside {0000000, 0100000}; 0100000 with funct3 not in {000, 101}; OP-IMM shifts with illegal funct7.
REQ-021 SHALL issue illegal entries with oIllegal=1, oOP=ADD, oA=oB=0, oRd=0.
REQ-022 SHALL set oRd=instr[11:7] for legal entries.
REQ-023 SHALL present an accepted instruction on the outputs with oValid=1 on the next cycle (1-cycle latency), sustaining 1 op/cycle while iReady=1.
REQ-024 SHALL hold the output entry stable while oValid && !iReady.
REQ-025 SHALL use a 2-entry skid buffer (output register plus skid register) with states EMPTY, ONE, TWO.
REQ-026 SHALL transition EMPTY->ONE on accept.
REQ-027 SHALL in ONE: accept with iReady -> ONE (replace); accept with !iReady -> TWO (new entry to skid); no accept with iReady -> EMPTY.
REQ-028 SHALL in TWO on iReady promote the skid entry to the output register -> ONE; input is not accepted in TWO.
REQ-029 SHALL drive oReady=1 iff state != TWO; registered, no combinational path from iReady.
REQ-030 SHALL on iFlush go to EMPTY next cycle, oValid=0, dropping a simultaneous input.

Reset
REQ-031 SHALL, while nRst=0 at an edge, force state EMPTY, oValid=0, oReady=0, oOP=0, oA=oB=0, oRd=0, oIllegal=0.
REQ-032 SHALL assert oReady=1 on the first cycle after nRst rises; reset mid-stall discards both entries.

Structure
REQ-033 SHALL take ALU opcode constants (REQ-014) and RV32I opcode constants from a shared package, so ALU and issue use one definition.
REQ-034 SHALL place the combinational decoder in one sub-module, alu_decode, feeding the skid buffer in alu_issue.

Verification
REQ-035 SHALL cover: add x3,x1,x2 with iRs1=5, iRs2=7 -> next cycle oValid=1, oOP=0, oA=5, oB=7, oRd=3.
REQ-036 SHALL cover: srai x4,x1,3 (0x4030D213) -> oOP=7, oB=3; sub -> oOP=1; slti imm=-1 -> oOP=8, oB=0xFFFFFFFF.
REQ-037 SHALL cover: auipc x1,0x12345 with iPC=0x100 -> oOP=0, oA=0x100, oB=0x12345000.
REQ-038 SHALL cover: iReady=0 with back-to-back instr X then Y -> oReady=0 the cycle after Y; X held stable; iReady=1 -> X, then Y, in order; none lost.
REQ-039 SHALL cover: opcode 0000011 (load) -> oIllegal=1, oOP=0, oA=oB=0, oRd=0.
REQ-040 SHALL cover: TWO state plus iFlush with iValid=1 -> next cycle oValid=0, oReady=1, and the input is not issued; nRst=0 mid-stream -> all outputs 0.
